q_update_ctrl: RTL

Q_UPDATE_CTRL -- requirements
Module: q_update_ctrl

---
 rtl/q_update_ctrl_pkg.sv | 30 +++
 rtl/q_update_ctrl_max_select.sv | 21 ++
 rtl/q_update_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/q_update_ctrl_pkg.sv
// Shared sizing, FSM encoding and saturation helper for the Q-learning update controller.
package q_update_ctrl_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int STATES        = 16;
  localparam int STATES_WIDTH  = 4;
  localparam int ACTIONS       = 4;
  localparam int ACTIONS_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CALC  = 2'd2,
    ST_WRITE = 2'd3
  } q_state_e;

  // Clamp a two-guard-bit value into the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] sat_data(input logic signed [DATA_WIDTH+1:0] v);
    logic [DATA_WIDTH-1:0] res;
    if ((v[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b000) || (v[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b111)) begin
      res = v[DATA_WIDTH-1:0];
    end else if (v[DATA_WIDTH+1]) begin
      res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/q_update_ctrl_max_select.sv
// Combinational signed maximum over ACTIONS packed Q entries.
module q_max_select
  import q_update_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH*ACTIONS-1:0] entries,
  output logic signed [DATA_WIDTH-1:0]  max_val
);

  // Linear scan; ties keep the lower action index.
  always_comb begin
    max_val = $signed(entries[DATA_WIDTH-1:0]);
    for (int k = 1; k < ACTIONS; k++) begin
      if ($signed(entries[k*DATA_WIDTH +: DATA_WIDTH]) > max_val) begin
        max_val = $signed(entries[k*DATA_WIDTH +: DATA_WIDTH]);
      end else begin
        max_val = max_val;
      end
    end
  end

endmodule

// File: rtl/q_update_ctrl.sv
// Q(s,a) update sequencer: read Q(s,a)/Q(s',*), compute the TD update, write back.
module q_update_ctrl
  import q_update_ctrl_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [STATES_WIDTH-1:0]       i_st,
  input  logic [STATES_WIDTH-1:0]       i_next_st,
  input  logic [ACTIONS_WIDTH-1:0]      i_at,
  input  logic [DATA_WIDTH-1:0]         i_reward,
  output logic                          o_re,
  output logic                          o_we,
  output logic [STATES_WIDTH-1:0]       o_st,
  output logic [STATES_WIDTH-1:0]       o_next_st,
  output logic [ACTIONS_WIDTH-1:0]      o_at,
  output logic [DATA_WIDTH-1:0]         o_data,
  input  logic [DATA_WIDTH-1:0]         i_q,
  input  logic [DATA_WIDTH*ACTIONS-1:0] i_next_q,
  output logic                          o_done
);

  localparam int EW = DATA_WIDTH + 2;

  q_state_e                  state_r, next_state_s;
  logic                      handshake_s;
  logic                      ready_r, re_r, we_r, done_r;
  logic [STATES_WIDTH-1:0]   st_r, next_st_r;
  logic [ACTIONS_WIDTH-1:0]  at_r;
  logic [DATA_WIDTH-1:0]     reward_r, q_r, max_r;
  logic signed [DATA_WIDTH-1:0] max_s;
  logic signed [EW-1:0]      max_e_s, q_e_s, r_e_s, target_s, delta_s, new_s;

  q_max_select u_max (
    .entries (i_next_q),
    .max_val (max_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a handshake is only possible from IDLE.
  always_comb begin
    next_state_s = state_r;
    handshake_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          next_state_s = ST_READ;
          handshake_s  = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_READ:  next_state_s = ST_CALC;
      ST_CALC:  next_state_s = ST_WRITE;
      ST_WRITE: next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Request latches, strobes and CALC-stage operand capture; strobes lead the state by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r   <= 1'b1;
      re_r      <= 1'b0;
      we_r      <= 1'b0;
      done_r    <= 1'b0;
      st_r      <= '0;
      next_st_r <= '0;
      at_r      <= '0;
      reward_r  <= '0;
      q_r       <= '0;
      max_r     <= '0;
    end else begin
      ready_r <= (next_state_s == ST_IDLE);
      re_r    <= handshake_s;
      we_r    <= (state_r == ST_CALC);
      done_r  <= (state_r == ST_CALC);
      if (handshake_s) begin
        st_r      <= i_st;
        next_st_r <= i_next_st;
        at_r      <= i_at;
        reward_r  <= i_reward;
      end
      if (state_r == ST_CALC) begin
        q_r   <= i_q;
        max_r <= max_s;
      end
    end
  end

  // Two guard bits keep r + max - max*2^-G and the delta free of overflow.
  assign max_e_s  = {{2{max_r[DATA_WIDTH-1]}}, max_r};
  assign q_e_s    = {{2{q_r[DATA_WIDTH-1]}}, q_r};
  assign r_e_s    = {{2{reward_r[DATA_WIDTH-1]}}, reward_r};
  assign target_s = r_e_s + max_e_s - (max_e_s >>> GAMMA_SHIFT);
  assign delta_s  = target_s - q_e_s;
  assign new_s    = q_e_s + (delta_s >>> ALPHA_SHIFT);

  assign o_ready   = ready_r;
  assign o_re      = re_r;
  assign o_we      = we_r;
  assign o_done    = done_r;
  assign o_st      = st_r;
  assign o_next_st = next_st_r;
  assign o_at      = at_r;
  assign o_data    = sat_data(new_s);

endmodule
